// File: rtl/dm_unit.sv
// Data-memory responder for the MEM stage: byte-lane stores, registered extended loads,
// alignment checking, and a post-reset clear sequencer that zeroes the whole array.
module dm_unit #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  DMWr,
    input  logic [2:0]  DMRe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        misalign,
    output logic        busy
);

    localparam int unsigned Words = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  misalign_q, misalign_d;
    logic                  busy_q, busy_d;

    logic [31:0]           mem_q [Words];

    logic [ADDR_WIDTH-1:0] widx;
    logic                  st_op, ld_op, st_mis, ld_mis;
    logic [3:0]            st_be;
    logic [31:0]           st_data;
    logic [31:0]           rd_word, ld_ext;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wd;

    logic                  unused_addr;
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    assign widx  = addr[ADDR_WIDTH+1:2];
    assign st_op = (DMWr != 2'd0);
    assign ld_op = (DMRe >= 3'd1) && (DMRe <= 3'd5);

    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata;
        st_mis  = 1'b0;
        unique case (DMWr)
            2'd1: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'd2: begin
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
                st_mis  = addr[0];
            end
            2'd3: st_mis = |addr[1:0];
            default: st_be = 4'b0000;
        endcase
    end

    // Load data is taken from the array in the request cycle and extended before registering.
    always_comb begin
        rd_word = mem_q[widx];
        rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
        rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_mis  = 1'b0;
        unique case (DMRe)
            3'd1: ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd2: ld_ext = {24'h0, rd_byte};
            3'd3: begin
                ld_ext = {{16{rd_half[15]}}, rd_half};
                ld_mis = addr[0];
            end
            3'd4: begin
                ld_ext = {16'h0, rd_half};
                ld_mis = addr[0];
            end
            3'd5: begin
                ld_ext = rd_word;
                ld_mis = |addr[1:0];
            end
            default: ld_ext = rd_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = widx;
        mem_be     = st_be;
        mem_wd     = st_data;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_idx   = clr_idx_q;
                mem_be    = 4'b1111;
                mem_wd    = 32'h0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (&clr_idx_q) begin
                    state_d = StRun;
                    busy_d  = 1'b0;
                end
            end
            StRun: begin
                // A store takes priority; a load presented alongside it is dropped.
                if (st_op) begin
                    if (st_mis) misalign_d = 1'b1;
                    else        mem_we     = 1'b1;
                end else if (ld_op) begin
                    if (ld_mis) begin
                        misalign_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = ld_ext;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_idx_q  <= '0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem_q[mem_idx][8*k +: 8] <= mem_wd[8*k +: 8];
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;
    assign busy     = busy_q;

endmodule
